// File: rtl/data_mem_responder.sv
// Data-memory responder: doubleword store behind a valid/ready handshake,
// one outstanding access, programmable wait states before each access.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic        ReqReady,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] ReadData,
    output logic        RespErr
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = 8;
    localparam logic [63:0] LIMIT   = 64'(DEPTH) << 3;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_write;
    logic [63:0]        lat_addr;
    logic [63:0]        lat_wdata;
    logic [63:0]        mem [DEPTH];

    logic               addr_err;
    logic               do_access;
    logic               mem_we;
    logic [IDX_W-1:0]   idx;

    // Decode from the latched request so the live bus may change during BUSY.
    assign addr_err  = (lat_addr[2:0] != 3'd0) || (lat_addr >= LIMIT);
    assign idx       = lat_addr[IDX_W+2:3];
    assign do_access = (state == BUSY) && (cnt == '0);
    assign mem_we    = do_access && lat_write && !addr_err && !Reset;

    // Storage is never reset; a write only happens on the access edge.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= lat_wdata;
        end
    end

    // ReqReady comes up one edge after reset release, so accepts only ever
    // happen on edges where ReqReady was visibly high.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ReqReady  <= 1'b0;
            RespValid <= 1'b0;
            ReadData  <= '0;
            RespErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid && ReqReady) begin
                        lat_write <= ReqWrite;
                        lat_addr  <= Address;
                        lat_wdata <= WriteData;
                        cnt       <= WAIT_INIT;
                        RespErr   <= 1'b0;
                        ReqReady  <= 1'b0;
                        state     <= BUSY;
                    end else begin
                        ReqReady  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        RespValid <= 1'b1;
                        RespErr   <= addr_err;
                        ReadData  <= (addr_err || lat_write) ? 64'd0 : mem[idx];
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        ReqReady  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ReqReady  <= 1'b0;
                    RespValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: requests push expected responses,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned WAIT  = 2;
    localparam logic [63:0] TOP   = 64'(DEPTH) * 64'd8;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] read_data;
    logic        resp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pcount = 0;
    logic        prev_rv = 1'b0;
    exp_t        exp_q[$];
    logic [63:0] model [logic [63:0]];

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .ReqValid  (req_valid),
        .ReqWrite  (req_write),
        .Address   (address),
        .WriteData (write_data),
        .ReqReady  (req_ready),
        .RespValid (resp_valid),
        .RespReady (resp_ready),
        .ReadData  (read_data),
        .RespErr   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcount <= pcount + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: latency on the rising RespValid, payload on handover.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid && !prev_rv) begin
                if (exp_q.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
                else check("latency", 64'(pcount - exp_q[0].acc), 64'(WAIT + 1));
            end
            if (resp_valid && resp_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("read_data", read_data, e.data);
                check("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
        prev_rv = resp_valid;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input bit track, output int unsigned acc);
        int   n = 0;
        exp_t e;
        logic err;
        acc = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        address    = addr;
        write_data = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = pcount;
        check("busy_ready_low", 64'(req_ready), 64'd0);
        if (track) begin
            err    = (addr[2:0] != 3'd0) || (addr >= TOP);
            e.err  = err;
            e.acc  = acc;
            e.data = (err || wr) ? 64'd0 : model[addr];
            if (!err && wr) model[addr] = wd;
            exp_q.push_back(e);
        end
    endtask

    task automatic req(input logic wr, input logic [63:0] addr, input logic [63:0] wd);
        int unsigned acc;
        issue(wr, addr, wd, 1'b1, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int unsigned a0, a1;
        logic [63:0] held;
        int n;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; address = '0;
        write_data = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_read_data", read_data, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store then load, latency checked by the monitor.
        req(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567);
        req(1'b0, 64'h10, 64'h0);
        drain();

        // Back-to-back loads with RespReady held high.
        req(1'b1, 64'h0, 64'h1111_2222_3333_4444);
        req(1'b1, 64'h8, 64'h5555_6666_7777_8888);
        drain();
        issue(1'b0, 64'h0, 64'h0, 1'b1, a0);
        issue(1'b0, 64'h8, 64'h0, 1'b1, a1);
        check("b2b_period", 64'(a1 - a0), 64'(WAIT + 3));
        drain();

        // Errors: misaligned and out-of-range, memory untouched.
        req(1'b0, 64'h13, 64'h0);
        req(1'b0, TOP, 64'h0);
        req(1'b1, 64'h11, 64'hBAD0_BAD0_BAD0_BAD0);
        req(1'b1, TOP, 64'hBAD1_BAD1_BAD1_BAD1);
        req(1'b0, 64'h10, 64'h0);
        req(1'b0, 64'h0, 64'h0);
        drain();

        // Response held: outputs stable, new requests ignored.
        resp_ready = 1'b0;
        req(1'b0, 64'h10, 64'h0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_resp_seen", 64'(resp_valid), 64'd1);
        held = read_data;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; address = 64'h30;
            write_data = 64'hCAFE_F00D_0000_0000 | 64'(i);
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", read_data, held);
            check("hold_ready_low", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hold_ready", 64'(req_ready), 64'd1);
        check("post_hold_valid", 64'(resp_valid), 64'd0);
        drain();
        req(1'b1, 64'h30, 64'h0123_0123_0123_0123);
        req(1'b0, 64'h30, 64'h0);
        drain();

        // Reset during BUSY drops a pending store.
        req(1'b1, 64'h20, 64'hA5A5_5A5A_A5A5_5A5A);
        req(1'b0, 64'h10, 64'h0);
        drain();
        issue(1'b1, 64'h20, 64'hFFFF_0000_FFFF_0000, 1'b0, a0);
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_read_data", read_data, 64'd0);
        check("midrst_resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_resp", 64'(resp_valid), 64'd0);
        req(1'b0, 64'h20, 64'h0);
        drain();

        // Last entry and first entry independence.
        req(1'b1, TOP - 64'd8, 64'hFEED_FACE_0BAD_C0DE);
        req(1'b0, TOP - 64'd8, 64'h0);
        req(1'b0, 64'h0, 64'h0);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
